// File: rtl/piped_adder_feeder_pkg.sv
// Shared types and helpers for the adder-tree argument framer.
// Imported by the framer top and its slot decoder.
package piped_adder_feeder_pkg;

    // What the framer does with its assembly buffer on the coming edge.
    typedef enum logic [1:0] {
        ACT_ACCUM  = 2'd0,
        ACT_EMIT   = 2'd1,
        ACT_RESYNC = 2'd2
    } feeder_action_e;

    // Fill counter width: log2 of the frame length, never narrower than one bit.
    function automatic int fill_width(input int n_args);
        return (n_args <= 2) ? 1 : $clog2(n_args);
    endfunction

endpackage

// File: rtl/piped_adder_feeder_if.sv
// Sample stream in, assembled argument bus out; the framer is the slave side.
// Parameters must match those of the framer instance it connects to.
interface piped_adder_feeder_if
    import piped_adder_feeder_pkg::*;
#(
    parameter int N_args    = 8,
    parameter int arg_width = 4
) ();
    localparam int cnt_width = fill_width(N_args);

    logic [arg_width-1:0]        din;
    logic                        din_valid;
    logic                        sync;
    logic                        flush;
    logic [N_args*arg_width-1:0] args_out;
    logic                        we;
    logic [cnt_width-1:0]        fill;
    logic                        discard;

    modport master (
        output din, din_valid, sync, flush,
        input  args_out, we, fill, discard
    );

    modport slave (
        input  din, din_valid, sync, flush,
        output args_out, we, fill, discard
    );
endinterface

// File: rtl/piped_adder_feeder_slot_decode.sv
// Turns the write index into a one-hot slot enable, gated by the accept strobe.
// Exactly one slot is written per accepted sample; none otherwise.
module piped_adder_feeder_slot_decode #(
    parameter int N_args    = 8,
    parameter int cnt_width = 3
) (
    input  logic [cnt_width-1:0] idx,
    input  logic                 en,
    output logic [N_args-1:0]    slot_en
);
    genvar gi;
    generate
        for (gi = 0; gi < N_args; gi++) begin : g_slot
            assign slot_en[gi] = en && (idx == cnt_width'(gi));
        end
    endgenerate
endmodule

// File: rtl/piped_adder_feeder.sv
// Serial-to-parallel framer feeding the pipelined adder tree: gathers N_args
// samples, then presents them on args_out with a one-cycle we pulse.
module piped_adder_feeder
    import piped_adder_feeder_pkg::*;
#(
    parameter int N_args    = 8,
    parameter int arg_width = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    piped_adder_feeder_if.slave  bus
);
    localparam int cnt_width = fill_width(N_args);
    localparam int bus_width = N_args * arg_width;
    localparam logic [cnt_width-1:0] last_slot = cnt_width'(N_args - 1);

    logic [bus_width-1:0] asm_reg;
    logic [bus_width-1:0] asm_next;
    logic [bus_width-1:0] out_reg;
    logic [cnt_width-1:0] fill_reg;
    logic [cnt_width-1:0] fill_next;
    logic [cnt_width-1:0] write_idx;
    logic                 we_reg;
    logic                 discard_reg;
    logic [N_args-1:0]    slot_en;
    logic                 completes;
    logic                 has_samples;
    feeder_action_e       action;

    // Completion outranks flush and sync; flush outranks sync so a flushed
    // partial frame is emitted rather than discarded.
    always_comb begin
        completes   = bus.din_valid && (fill_reg == last_slot);
        has_samples = bus.din_valid || (fill_reg != '0);
        action      = ACT_ACCUM;
        if (completes || (bus.flush && has_samples)) begin
            action = ACT_EMIT;
        end else if (bus.sync) begin
            action = ACT_RESYNC;
        end

        write_idx = (action == ACT_RESYNC) ? '0 : fill_reg;

        fill_next = fill_reg;
        case (action)
            ACT_EMIT:   fill_next = '0;
            ACT_RESYNC: fill_next = cnt_width'(bus.din_valid);
            default:    fill_next = fill_reg + cnt_width'(bus.din_valid);
        endcase
    end

    piped_adder_feeder_slot_decode #(
        .N_args    (N_args),
        .cnt_width (cnt_width)
    ) u_slot_decode (
        .idx     (write_idx),
        .en      (bus.din_valid),
        .slot_en (slot_en)
    );

    // Buffer with the incoming sample merged in; on resync the old contents
    // are dropped so a same-cycle sample lands alone in slot 0.
    genvar gi;
    generate
        for (gi = 0; gi < N_args; gi++) begin : g_merge
            assign asm_next[gi*arg_width +: arg_width] =
                slot_en[gi]              ? bus.din :
                (action == ACT_RESYNC)   ? '0      :
                                           asm_reg[gi*arg_width +: arg_width];
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            asm_reg     <= '0;
            out_reg     <= '0;
            fill_reg    <= '0;
            we_reg      <= 1'b0;
            discard_reg <= 1'b0;
        end else begin
            asm_reg     <= (action == ACT_EMIT) ? '0 : asm_next;
            if (action == ACT_EMIT) begin
                out_reg <= asm_next;
            end
            fill_reg    <= fill_next;
            we_reg      <= (action == ACT_EMIT);
            discard_reg <= (action == ACT_RESYNC) && (fill_reg != '0);
        end
    end

    assign bus.args_out = out_reg;
    assign bus.we       = we_reg;
    assign bus.fill     = fill_reg;
    assign bus.discard  = discard_reg;
endmodule

// File: tb/tb_piped_adder_feeder.sv
// Directed test of the framer with four 4-bit slots per frame.
module tb_piped_adder_feeder;
    localparam int N = 4;
    localparam int W = 4;

    logic clk;
    logic resetn;
    int   total  = 0;
    int   passed = 0;

    piped_adder_feeder_if #(.N_args(N), .arg_width(W)) bus ();

    piped_adder_feeder #(.N_args(N), .arg_width(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one cycle of inputs (called at a negedge), return at the next
    // negedge with the registered outputs settled, inputs back to idle.
    task automatic cycle(input logic v, input logic [3:0] d, input logic s, input logic f);
        bus.din_valid = v;
        bus.din       = d;
        bus.sync      = s;
        bus.flush     = f;
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.din       = 4'h0;
        bus.sync      = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (bus.args_out !== 16'h0000) $display("FAIL reset_args: got %h expected %h", bus.args_out, 16'h0000); else passed++;
        total++; if (bus.we !== 1'b0) $display("FAIL reset_we: got %b expected %b", bus.we, 1'b0); else passed++;
        total++; if (bus.fill !== 2'd0) $display("FAIL reset_fill: got %0d expected %0d", bus.fill, 0); else passed++;
        total++; if (bus.discard !== 1'b0) $display("FAIL reset_discard: got %b expected %b", bus.discard, 1'b0); else passed++;
        $display("reset: args=%h we=%b fill=%0d discard=%b", bus.args_out, bus.we, bus.fill, bus.discard);
    endtask

    task automatic test_full_frame();
        cycle(1'b1, 4'h1, 1'b0, 1'b0);
        total++; if (bus.fill !== 2'd1) $display("FAIL full_fill1: got %0d expected %0d", bus.fill, 1); else passed++;
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        total++; if (bus.fill !== 2'd2) $display("FAIL full_fill2: got %0d expected %0d", bus.fill, 2); else passed++;
        cycle(1'b1, 4'h3, 1'b0, 1'b0);
        total++; if (bus.fill !== 2'd3) $display("FAIL full_fill3: got %0d expected %0d", bus.fill, 3); else passed++;
        total++; if (bus.we !== 1'b0) $display("FAIL full_we_early: got %b expected %b", bus.we, 1'b0); else passed++;
        cycle(1'b1, 4'h4, 1'b0, 1'b0);
        total++; if (bus.fill !== 2'd0) $display("FAIL full_fill0: got %0d expected %0d", bus.fill, 0); else passed++;
        total++; if (bus.we !== 1'b1) $display("FAIL full_we: got %b expected %b", bus.we, 1'b1); else passed++;
        total++; if (bus.args_out !== 16'h4321) $display("FAIL full_args: got %h expected %h", bus.args_out, 16'h4321); else passed++;
        $display("full_frame: args=%h we=%b fill=%0d", bus.args_out, bus.we, bus.fill);
        cycle(1'b0, 4'h0, 1'b0, 1'b0);
        total++; if (bus.we !== 1'b0) $display("FAIL full_we_pulse: got %b expected %b", bus.we, 1'b0); else passed++;
        total++; if (bus.args_out !== 16'h4321) $display("FAIL full_args_hold: got %h expected %h", bus.args_out, 16'h4321); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_tbl [3];
        logic        exp_we;
        exp_tbl[0] = 16'h3210;
        exp_tbl[1] = 16'h7654;
        exp_tbl[2] = 16'hBA98;
        for (int i = 0; i < 12; i++) begin
            bus.din_valid = 1'b1;
            bus.din       = 4'(i);
            @(negedge clk);
            exp_we = (i % 4 == 3);
            total++; if (bus.we !== exp_we) $display("FAIL b2b_we[%0d]: got %b expected %b", i, bus.we, exp_we); else passed++;
            if (exp_we) begin
                total++; if (bus.args_out !== exp_tbl[i/4]) $display("FAIL b2b_args[%0d]: got %h expected %h", i, bus.args_out, exp_tbl[i/4]); else passed++;
                $display("back_to_back: sample %0d args=%h we=%b", i, bus.args_out, bus.we);
            end
        end
        bus.din_valid = 1'b0;
        bus.din       = 4'h0;
    endtask

    task automatic test_flush();
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        total++; if (bus.we !== 1'b0) $display("FAIL flush_empty_we: got %b expected %b", bus.we, 1'b0); else passed++;
        cycle(1'b1, 4'h5, 1'b0, 1'b0);
        cycle(1'b1, 4'h6, 1'b0, 1'b0);
        cycle(1'b0, 4'h0, 1'b0, 1'b1);
        total++; if (bus.we !== 1'b1) $display("FAIL flush_we: got %b expected %b", bus.we, 1'b1); else passed++;
        total++; if (bus.args_out !== 16'h0065) $display("FAIL flush_args: got %h expected %h", bus.args_out, 16'h0065); else passed++;
        total++; if (bus.fill !== 2'd0) $display("FAIL flush_fill: got %0d expected %0d", bus.fill, 0); else passed++;
        $display("flush: args=%h we=%b fill=%0d", bus.args_out, bus.we, bus.fill);
        cycle(1'b1, 4'h1, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        cycle(1'b1, 4'h3, 1'b0, 1'b0);
        cycle(1'b1, 4'h4, 1'b0, 1'b0);
        total++; if (bus.args_out !== 16'h4321) $display("FAIL flush_next_args: got %h expected %h", bus.args_out, 16'h4321); else passed++;
        $display("flush_next: args=%h we=%b", bus.args_out, bus.we);
    endtask

    task automatic test_sync();
        cycle(1'b0, 4'h0, 1'b1, 1'b0);
        total++; if (bus.discard !== 1'b0) $display("FAIL sync_empty_discard: got %b expected %b", bus.discard, 1'b0); else passed++;
        cycle(1'b1, 4'h7, 1'b0, 1'b0);
        cycle(1'b1, 4'h9, 1'b1, 1'b0);
        total++; if (bus.discard !== 1'b1) $display("FAIL sync_discard: got %b expected %b", bus.discard, 1'b1); else passed++;
        total++; if (bus.we !== 1'b0) $display("FAIL sync_we: got %b expected %b", bus.we, 1'b0); else passed++;
        total++; if (bus.fill !== 2'd1) $display("FAIL sync_fill: got %0d expected %0d", bus.fill, 1); else passed++;
        $display("sync: discard=%b we=%b fill=%0d", bus.discard, bus.we, bus.fill);
        cycle(1'b1, 4'hA, 1'b0, 1'b0);
        total++; if (bus.discard !== 1'b0) $display("FAIL sync_discard_pulse: got %b expected %b", bus.discard, 1'b0); else passed++;
        cycle(1'b1, 4'hB, 1'b0, 1'b0);
        cycle(1'b1, 4'hC, 1'b0, 1'b0);
        total++; if (bus.we !== 1'b1) $display("FAIL sync_next_we: got %b expected %b", bus.we, 1'b1); else passed++;
        total++; if (bus.args_out !== 16'hCBA9) $display("FAIL sync_next_args: got %h expected %h", bus.args_out, 16'hCBA9); else passed++;
        $display("sync_next: args=%h we=%b", bus.args_out, bus.we);
    endtask

    task automatic test_sync_complete();
        cycle(1'b1, 4'h1, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        cycle(1'b1, 4'h3, 1'b0, 1'b0);
        cycle(1'b1, 4'h4, 1'b1, 1'b0);
        total++; if (bus.we !== 1'b1) $display("FAIL synccmp_we: got %b expected %b", bus.we, 1'b1); else passed++;
        total++; if (bus.args_out !== 16'h4321) $display("FAIL synccmp_args: got %h expected %h", bus.args_out, 16'h4321); else passed++;
        total++; if (bus.discard !== 1'b0) $display("FAIL synccmp_discard: got %b expected %b", bus.discard, 1'b0); else passed++;
        total++; if (bus.fill !== 2'd0) $display("FAIL synccmp_fill: got %0d expected %0d", bus.fill, 0); else passed++;
        $display("sync_complete: args=%h we=%b discard=%b fill=%0d", bus.args_out, bus.we, bus.discard, bus.fill);
    endtask

    task automatic test_flush_sync();
        cycle(1'b1, 4'h5, 1'b0, 1'b0);
        cycle(1'b1, 4'h6, 1'b1, 1'b1);
        total++; if (bus.we !== 1'b1) $display("FAIL flsync_we: got %b expected %b", bus.we, 1'b1); else passed++;
        total++; if (bus.args_out !== 16'h0065) $display("FAIL flsync_args: got %h expected %h", bus.args_out, 16'h0065); else passed++;
        total++; if (bus.discard !== 1'b0) $display("FAIL flsync_discard: got %b expected %b", bus.discard, 1'b0); else passed++;
        total++; if (bus.fill !== 2'd0) $display("FAIL flsync_fill: got %0d expected %0d", bus.fill, 0); else passed++;
        $display("flush_sync: args=%h we=%b discard=%b fill=%0d", bus.args_out, bus.we, bus.discard, bus.fill);
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 4'h1, 1'b0, 1'b0);
        cycle(1'b1, 4'h2, 1'b0, 1'b0);
        #2 resetn = 1'b0;
        #1;
        total++; if (bus.args_out !== 16'h0000) $display("FAIL areset_args: got %h expected %h", bus.args_out, 16'h0000); else passed++;
        total++; if (bus.fill !== 2'd0) $display("FAIL areset_fill: got %0d expected %0d", bus.fill, 0); else passed++;
        total++; if (bus.we !== 1'b0) $display("FAIL areset_we: got %b expected %b", bus.we, 1'b0); else passed++;
        $display("async_reset: args=%h we=%b fill=%0d", bus.args_out, bus.we, bus.fill);
        @(negedge clk);
        resetn = 1'b1;
        cycle(1'b0, 4'h0, 1'b0, 1'b0);
        total++; if (bus.we !== 1'b0) $display("FAIL areset_no_we: got %b expected %b", bus.we, 1'b0); else passed++;
        cycle(1'b1, 4'h5, 1'b0, 1'b0);
        cycle(1'b1, 4'h6, 1'b0, 1'b0);
        cycle(1'b1, 4'h7, 1'b0, 1'b0);
        cycle(1'b1, 4'h8, 1'b0, 1'b0);
        total++; if (bus.we !== 1'b1) $display("FAIL areset_next_we: got %b expected %b", bus.we, 1'b1); else passed++;
        total++; if (bus.args_out !== 16'h8765) $display("FAIL areset_next_args: got %h expected %h", bus.args_out, 16'h8765); else passed++;
        $display("after_reset: args=%h we=%b", bus.args_out, bus.we);
    endtask

    initial begin
        bus.din       = 4'h0;
        bus.din_valid = 1'b0;
        bus.sync      = 1'b0;
        bus.flush     = 1'b0;
        resetn        = 1'b1;
        #1 resetn = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        resetn = 1'b1;
        test_full_frame();
        test_back_to_back();
        test_flush();
        test_sync();
        test_sync_complete();
        test_flush_sync();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/piped_adder_feeder.md
Name: piped_adder_feeder

Overview:
- Serial-to-parallel framer that builds the argument bus for the pipelined adder tree.
- Collects N_args serial samples into one bus, then presents the bus with a one-cycle we pulse. The adder consumes the bus; this block is its producer.
- Used where samples arrive one per cycle or sparsely, e.g. correlator chips, and must be summed in blocks of N_args.
- Supports epoch re-alignment (sync) and early emission of a partial, zero-padded frame (flush).

Parameters:
- N_args, 8, number of samples per frame; must be >= 1.
- arg_width, 4, bits per sample.
- cnt_width, log2(N_args) with a minimum of 1, width of the fill counter. Derived; never override.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- din  in  arg_width  serial sample.
- din_valid  in  1  din is valid this cycle.
- sync  in  1  epoch marker; restarts framing.
- flush  in  1  emit the current partial frame now.
- args_out  out  N_args*arg_width  assembled frame. Slot k is bits [k*arg_width +: arg_width]; slot 0 is the first sample received.
- we  out  1  one-cycle pulse; args_out is new this cycle. Connects to the adder's we input.
- fill  out  cnt_width  number of samples held in the current partial frame.
- discard  out  1  one-cycle pulse; sync dropped a non-empty partial frame.

Behaviour:
- Reset (resetn=0, asynchronous): args_out=0, we=0, fill=0, discard=0, assembly buffer=0. Effect is immediate, including mid-frame; the partial frame is lost and no we is generated.
- Storage:
  - An assembly buffer accepts incoming samples.
  - A separate output register drives args_out.
  - args_out changes only on the clock edge where we rises, and holds its value until the next emission.
- Accept: when din_valid=1, din is written into assembly slot fill and fill increments. No other slot changes.
- Frame complete: a sample accepted while fill=N_args-1 completes the frame. At the next edge:
  - the output register loads the complete buffer;
  - we=1 for one cycle;
  - fill=0;
  - the assembly buffer clears to 0.
- Latency: one clock from the completing din_valid to we/args_out. Back-to-back frames at full rate (din_valid held high) must give one we every N_args cycles with no lost samples.
- Flush:
  - If flush=1 and the frame holds at least one sample, counting a din accepted in the same cycle, the block emits like a complete frame. Unfilled slots are 0, which is neutral for the sum. we pulses and fill returns to 0.
  - Flush on an empty frame with no din is a no-op: no we.
- Sync:
  - sync=1 discards the assembly buffer and sets fill=0.
  - If the discarded frame held at least one sample, discard pulses on the next cycle.
  - A din_valid in the same cycle as sync is kept as slot 0 of the new frame, so fill becomes 1.
  - args_out and we are unaffected.
- Priority:
  - A sync that coincides with frame completion is ignored: the frame is emitted and fill goes to 0.
  - flush with sync: flush wins. The partial frame, including din, is emitted and discard stays 0.
- N_args=1: every valid sample produces we on the next cycle, and fill is always 0.
- Arithmetic: none. There is no backpressure, because the adder accepts a new bus every cycle.
- Size: 150–250 lines of RTL.

Decomposition:
- log2 comes from the shared math.v include. No new package.
- The slot write-enable decode (fill -> one-hot slot enable) may be a small sub-module, feeder_slot_decode. Inlining it is acceptable.
- Instantiate together with the adder in a wrapper. For this block, args_out maps to args_in and we maps to we.

Test Plan (N_args=4, arg_width=4):
- Feed 1,2,3,4 on consecutive cycles -> we pulses one cycle after the 4 is accepted; args_out=16'h4321; fill sequence 1,2,3,0.
- Feed din_valid high continuously for 12 samples 0..B -> three we pulses 4 cycles apart: 16'h3210, 16'h7654, 16'hBA98.
- Feed 5,6, then flush alone -> we with args_out=16'h0065; the next frame starts at slot 0.
- Feed 7, then sync with din=9 valid -> discard pulses; no we; fill=1. Feeding A,B,C then gives args_out=16'hCBA9.
- Feed 1,2,3, then sync together with din=4 valid -> frame emitted, args_out=16'h4321; discard=0.
- Feed 1,2, assert resetn=0 asynchronously between edges -> all outputs 0 immediately. After release, 5,6,7,8 -> args_out=16'h8765.
